// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: load-use interlock, redirect
// flush, multi-cycle divide hold and data-memory wait stalls.
module hazard_ctrl #(
    parameter int REG_BITS   = 5,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] D_rs1,
    input  logic [REG_BITS-1:0] D_rs2,
    input  logic                D_use_rs1,
    input  logic                D_use_rs2,
    input  logic [REG_BITS-1:0] EX_rd,
    input  logic                EX_is_load,
    input  logic                EX_is_div,
    input  logic                EX_taken,
    input  logic                MEM_req,
    input  logic                MEM_ready,
    output logic                stall_F,
    output logic                stall_D,
    output logic                stall_E,
    output logic                stall_M,
    output logic                flush_D,
    output logic                bubble_E,
    output logic                bubble_M,
    output logic                bubble_W,
    output logic                busy,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Control vector bit order: {stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, bubble_M, bubble_W}
    localparam logic [7:0] CTRL_NONE = 8'b0000_0000;
    localparam logic [7:0] CTRL_MEM  = 8'b1111_0001;
    localparam logic [7:0] CTRL_DIV  = 8'b1110_0010;
    localparam logic [7:0] CTRL_FLSH = 8'b0000_1100;
    localparam logic [7:0] CTRL_LDU  = 8'b1100_0100;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             mem_miss_s;
    logic             load_use_s;
    logic [7:0]       ctrl_s;

    // Priority of the non-memory RUN hazards: divide, redirect, load-use.
    function automatic logic [7:0] run_ctrl(input logic is_div, input logic taken,
                                            input logic ld_use);
        logic [7:0] c;
        if (is_div) begin
            c = CTRL_DIV;
        end else if (taken) begin
            c = CTRL_FLSH;
        end else if (ld_use) begin
            c = CTRL_LDU;
        end else begin
            c = CTRL_NONE;
        end
        return c;
    endfunction

    // Hazard detection terms shared by next-state and output logic.
    always_comb begin
        mem_miss_s = MEM_req & ~MEM_ready;
        load_use_s = EX_is_load & (EX_rd != {REG_BITS{1'b0}}) &
                     ((D_use_rs1 & (D_rs1 == EX_rd)) | (D_use_rs2 & (D_rs2 == EX_rd)));
    end

    // State and divide countdown registers.
    always_ff @(posedge clk) begin
        state_r <= state_next_s;
        cnt_r   <= cnt_next_s;
    end

    // Next-state logic; a synchronous reset abandons any pending divide or miss.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (rst) begin
            state_next_s = RUN;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_miss_s) begin
                        state_next_s = MEM_WAIT;
                    end else if (EX_is_div) begin
                        state_next_s = DIV_WAIT;
                        cnt_next_s   = DIV_LAST;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                DIV_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!MEM_ready) begin
                        state_next_s = MEM_WAIT;
                    end else if (EX_is_div) begin
                        state_next_s = DIV_WAIT;
                        cnt_next_s   = DIV_LAST;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode; a divide release only honours a deferred redirect.
    always_comb begin
        ctrl_s = CTRL_NONE;
        if (rst) begin
            ctrl_s = CTRL_NONE;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_miss_s) begin
                        ctrl_s = CTRL_MEM;
                    end else begin
                        ctrl_s = run_ctrl(EX_is_div, EX_taken, load_use_s);
                    end
                end
                DIV_WAIT: begin
                    if (cnt_r != CNT_ZERO) begin
                        ctrl_s = CTRL_DIV;
                    end else if (EX_taken) begin
                        ctrl_s = CTRL_FLSH;
                    end else begin
                        ctrl_s = CTRL_NONE;
                    end
                end
                MEM_WAIT: begin
                    if (!MEM_ready) begin
                        ctrl_s = CTRL_MEM;
                    end else begin
                        ctrl_s = run_ctrl(EX_is_div, EX_taken, load_use_s);
                    end
                end
                default: begin
                    ctrl_s = CTRL_NONE;
                end
            endcase
        end
    end

    assign {stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, bubble_M, bubble_W} = ctrl_s;
    assign busy = ~rst & (state_r != RUN);

    // Saturating count of PC-hold cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall_F && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, compared each cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int REG_BITS   = 5;
    localparam int DIV_CYCLES = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [REG_BITS-1:0] D_rs1, D_rs2, EX_rd;
    logic                D_use_rs1, D_use_rs2, EX_is_load, EX_is_div, EX_taken;
    logic                MEM_req, MEM_ready;
    logic                stall_F, stall_D, stall_E, stall_M;
    logic                flush_D, bubble_E, bubble_M, bubble_W, busy;
    logic [15:0]         stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: pending divide with remaining stall cycles, pending miss, stall count.
    bit m_div  = 1'b0;
    int m_left = 0;
    bit m_mem  = 1'b0;
    int m_cnt  = 0;

    hazard_ctrl #(.REG_BITS(REG_BITS), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .EX_rd(EX_rd), .EX_is_load(EX_is_load), .EX_is_div(EX_is_div), .EX_taken(EX_taken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .bubble_E(bubble_E), .bubble_M(bubble_M), .bubble_W(bubble_W),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle_inputs();
        D_rs1 = '0; D_rs2 = '0; EX_rd = '0;
        D_use_rs1 = 1'b0; D_use_rs2 = 1'b0; EX_is_load = 1'b0; EX_is_div = 1'b0;
        EX_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    // One clock: predict from current inputs, check at negedge, advance model at posedge.
    task automatic cycle();
        logic [7:0] e;
        bit nd, nm, lu;
        int nl;
        @(negedge clk);
        e = 8'h00; nd = m_div; nm = m_mem; nl = m_left;
        lu = EX_is_load && (EX_rd != 0) &&
             ((D_use_rs1 && D_rs1 == EX_rd) || (D_use_rs2 && D_rs2 == EX_rd));
        if (rst) begin
            nd = 1'b0; nm = 1'b0; nl = 0;
        end else if (m_div) begin
            if (m_left > 0) begin
                e = 8'b1110_0010; nl = m_left - 1;
            end else begin
                if (EX_taken) e = 8'b0000_1100;
                nd = 1'b0;
            end
        end else if ((m_mem && !MEM_ready) || (!m_mem && MEM_req && !MEM_ready)) begin
            e = 8'b1111_0001; nm = 1'b1;
        end else begin
            nm = 1'b0;
            if (EX_is_div) begin
                e = 8'b1110_0010; nd = 1'b1; nl = DIV_CYCLES - 1;
            end else if (EX_taken) e = 8'b0000_1100;
            else if (lu) e = 8'b1100_0100;
        end
        chk("ctrl", {24'd0, stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, bubble_M, bubble_W},
            {24'd0, e});
        chk("busy", {31'd0, busy}, {31'd0, (!rst && (m_div || m_mem))});
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        @(posedge clk);
        if (rst) m_cnt = 0;
        else if (e[7] && m_cnt < 65535) m_cnt++;
        m_div = nd; m_left = nl; m_mem = nm;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // Load-use on rs1, then the same with x0 as destination.
        EX_is_load = 1'b1; EX_rd = 5'd5; D_rs1 = 5'd5; D_use_rs1 = 1'b1;
        cycle();
        EX_rd = 5'd0; D_rs1 = 5'd0;
        cycle();
        // Redirect overrides load-use.
        EX_rd = 5'd5; D_rs1 = 5'd5; EX_taken = 1'b1;
        cycle();
        idle_inputs();

        // Divide held in EX from a cleared counter.
        rst = 1'b1; cycle(); rst = 1'b0;
        EX_is_div = 1'b1;
        for (int i = 0; i < DIV_CYCLES + 1; i++) cycle();
        chk("div_stall_total", {16'd0, stall_cnt}, 32'd8);
        EX_is_div = 1'b0;
        cycle();

        // Memory wait of three cycles.
        MEM_req = 1'b1; MEM_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        MEM_ready = 1'b1; cycle();
        idle_inputs(); cycle();

        // Miss with a divide waiting in EX.
        rst = 1'b1; cycle(); rst = 1'b0;
        EX_is_div = 1'b1; MEM_req = 1'b1; MEM_ready = 1'b0;
        cycle(); cycle();
        MEM_ready = 1'b1; cycle();
        MEM_req = 1'b0;
        for (int i = 0; i < DIV_CYCLES; i++) cycle();
        chk("miss_div_stall_total", {16'd0, stall_cnt}, 32'd10);
        idle_inputs(); cycle();

        // Reset part-way through a divide.
        EX_is_div = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        EX_is_div = 1'b0;
        cycle();
        chk("post_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        // A fresh divide after reset must again take the full length.
        EX_is_div = 1'b1;
        for (int i = 0; i < DIV_CYCLES + 1; i++) cycle();
        EX_is_div = 1'b0;
        cycle();

        // Randomized traffic with a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            D_rs1      = REG_BITS'($urandom_range(0, 3));
            D_rs2      = REG_BITS'($urandom_range(0, 3));
            EX_rd      = REG_BITS'($urandom_range(0, 3));
            D_use_rs1  = $urandom_range(0, 1) == 1;
            D_use_rs2  = $urandom_range(0, 1) == 1;
            EX_is_load = $urandom_range(0, 1) == 1;
            EX_is_div  = $urandom_range(0, 9) == 0;
            EX_taken   = $urandom_range(0, 3) == 0;
            MEM_req    = m_div ? 1'b0 : ($urandom_range(0, 2) == 0);
            MEM_ready  = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
